// File: rtl/mult_issue_pkg.sv
// Shared types and constants for the multiplier issue block.
// State encoding, default parameters and busy-counter width live here.
package mult_issue_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      DONE
   } state_t;

   localparam int unsigned RD_W_DEFAULT           = 5;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 24;
   localparam int unsigned CNT_W                  = 5;
   // Multiplier ready is still asserted from the previous op for this many BUSY cycles.
   localparam int unsigned RDY_MIN_COUNT          = 2;

endpackage

// File: rtl/mult_cyc_counter.sv
// Saturating BUSY-cycle counter with synchronous clear and count enable.
module mult_cyc_counter
   import mult_issue_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mult_issue.sv
// Issue/writeback sequencer for a multi-cycle multiplier.
// Optional BUSY watchdog enabled by defining MULT_ISSUE_TIMEOUT_EN.
module mult_issue
   import mult_issue_pkg::*;
#(
   parameter int unsigned RD_W           = RD_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [RD_W-1:0] in_rd,
   output logic            stall,
   output logic [31:0]     mult_a,
   output logic [31:0]     mult_b,
   output logic            mult_ctr_rst,
   input  logic [31:0]     mult_result,
   input  logic            mult_exception,
   input  logic            mult_rdy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_result,
   output logic            out_exception,
   output logic [RD_W-1:0] out_rd,
   output logic            out_timeout
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] busy_cnt;
   logic [31:0]      a_q, b_q;
   logic [RD_W-1:0]  rd_q;
   logic [31:0]      result_q;
   logic             exc_q;
   logic [RD_W-1:0]  out_rd_q;
   logic             accept;
   logic             rdy_ok;
   logic             tmo_hit;
   logic             cnt_clear;
   logic             cnt_enable;

   assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept       = in_valid && in_ready;
   assign stall        = in_valid && !in_ready;
   assign out_valid    = (state_q == DONE);
   assign mult_ctr_rst = reset || (state_q == START);
   assign mult_a       = a_q;
   assign mult_b       = b_q;
   assign out_result   = result_q;
   assign out_exception = exc_q;
   assign out_rd       = out_rd_q;

   assign cnt_clear  = (state_q == START);
   assign cnt_enable = (state_q == BUSY);
   assign rdy_ok     = mult_rdy && (busy_cnt >= CNT_W'(RDY_MIN_COUNT));

   mult_cyc_counter u_cyc_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (busy_cnt)
   );

`ifdef MULT_ISSUE_TIMEOUT_EN
   logic timeout_q;
   assign tmo_hit     = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign out_timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign tmo_hit     = 1'b0;
   assign out_timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = START;
         START:   state_d = BUSY;
         BUSY:    if (rdy_ok || tmo_hit) state_d = DONE;
         DONE:    if (out_ready) state_d = in_valid ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         out_rd_q <= '0;
`ifdef MULT_ISSUE_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            rd_q <= in_rd;
         end
         // A real ready always wins over a watchdog expiry in the same cycle.
         if (state_q == BUSY) begin
            if (rdy_ok) begin
               result_q <= mult_result;
               exc_q    <= mult_exception;
               out_rd_q <= rd_q;
`ifdef MULT_ISSUE_TIMEOUT_EN
               timeout_q <= 1'b0;
            end else if (tmo_hit) begin
               result_q  <= '0;
               exc_q     <= 1'b1;
               out_rd_q  <= rd_q;
               timeout_q <= 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_issue.sv
// Scoreboard bench for mult_issue with a behavioural 16-step multiplier model.
// The model keeps a stale ready asserted for two cycles after each control reset.
module tb_mult_issue;
   import mult_issue_pkg::*;

   localparam int RD_W = 5;
   localparam int TMO  = 24;

   logic            clock = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_a, in_b;
   logic [RD_W-1:0] in_rd;
   logic            stall;
   logic [31:0]     mult_a, mult_b;
   logic            mult_ctr_rst;
   logic [31:0]     mult_result;
   logic            mult_exception;
   logic            mult_rdy;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic            out_exception;
   logic [RD_W-1:0] out_rd;
   logic            out_timeout;

   typedef struct {
      logic [31:0]     res;
      logic            exc;
      logic [RD_W-1:0] rd;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;

   mult_issue #(.RD_W(RD_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .in_rd          (in_rd),
      .stall          (stall),
      .mult_a         (mult_a),
      .mult_b         (mult_b),
      .mult_ctr_rst   (mult_ctr_rst),
      .mult_result    (mult_result),
      .mult_exception (mult_exception),
      .mult_rdy       (mult_rdy),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_exception  (out_exception),
      .out_rd         (out_rd),
      .out_timeout    (out_timeout)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   function automatic exp_t mul_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [RD_W-1:0] rd);
      logic signed [63:0] p;
      exp_t e;
      p = $signed(a) * $signed(b);
      e.res = p[31:0];
      e.exc = (p != {{32{p[31]}}, p[31:0]});
      e.rd  = rd;
      return e;
   endfunction

   // Multiplier model: result ready 16 steps after mult_ctr_rst.
   logic [31:0] m_a, m_b, m_res;
   logic        m_exc, m_rdy, m_busy, m_hold;
   int          m_steps, m_stale;
   exp_t        m_tmp;

   assign mult_rdy       = m_rdy && !m_hold;
   assign mult_result    = m_res;
   assign mult_exception = m_exc;

   always @(posedge clock) begin
      if (reset) begin
         m_rdy   <= 1'b1;
         m_res   <= 32'h0BAD_C0DE;
         m_exc   <= 1'b1;
         m_busy  <= 1'b0;
         m_stale <= 0;
         m_steps <= 0;
      end else if (mult_ctr_rst) begin
         m_busy  <= 1'b1;
         m_steps <= 0;
         m_stale <= 2;
         m_a     <= mult_a;
         m_b     <= mult_b;
      end else begin
         if (m_stale != 0) begin
            m_stale <= m_stale - 1;
            if (m_stale == 1) m_rdy <= 1'b0;
         end
         if (m_busy) begin
            if (m_steps == 15) begin
               m_tmp   = mul_model(m_a, m_b, '0);
               m_res  <= m_tmp.res;
               m_exc  <= m_tmp.exc;
               m_rdy  <= 1'b1;
               m_busy <= 1'b0;
            end else begin
               m_steps <= m_steps + 1;
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [RD_W-1:0] rd,
                        input exp_t e, output int acc_cyc, output bit ok);
      ok = 1'b0;
      acc_cyc = 0;
      in_a = a;
      in_b = b;
      in_rd = rd;
      in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) begin
         sb.push_back(e);
         @(negedge clock);
         acc_cyc = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_rd = '0;
      out_ready = 1'b1;
      m_hold = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (mult_ctr_rst !== 1'b1) $display("FAIL rst_ctr_rst: got %b expected 1", mult_ctr_rst); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if ({out_result, out_exception, out_rd, out_timeout} !== '0)
         $display("FAIL rst_outputs: got %h/%b/%h/%b expected 0", out_result, out_exception, out_rd, out_timeout);
      else passed++;
      total++; if ({mult_a, mult_b} !== 64'h0) $display("FAIL rst_operands: got %h %h expected 0", mult_a, mult_b); else passed++;
      reset = 1'b0;
      @(negedge clock);
      #1;
      total++; if (mult_ctr_rst !== 1'b0) $display("FAIL idle_ctr_rst: got %b expected 0", mult_ctr_rst); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready); else passed++;
   endtask

   task automatic test_basic();
      exp_t e;
      int   acc;
      bit   ok, seen;
      e.res = 32'd42; e.exc = 1'b0; e.rd = 5'h13;
      issue(32'd7, 32'd6, 5'h13, e, acc, ok);
      total++; if (!ok) $display("FAIL basic_accept: got no in_ready expected accept"); else passed++;
      total++; if ({mult_ctr_rst, mult_a, mult_b} !== {1'b1, 32'd7, 32'd6})
         $display("FAIL basic_start: got ctr_rst=%b a=%h b=%h expected 1 7 6", mult_ctr_rst, mult_a, mult_b);
      else passed++;
      wait_valid(40, seen);
      total++; if (!seen || (cyc - acc) > 20)
         $display("FAIL basic_latency: got seen=%b cycles=%0d expected <=20", seen, cyc - acc);
      else passed++;
      e = sb.pop_front();
      total++; if ({out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
         $display("FAIL basic_result: got %h/%b/%h expected %h/%b/%h", out_result, out_exception, out_rd, e.res, e.exc, e.rd);
      else passed++;
      total++; if (out_timeout !== 1'b0) $display("FAIL basic_timeout: got %b expected 0", out_timeout); else passed++;
      @(negedge clock);
      total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_idle: got valid=%b ready=%b expected 0 1", out_valid, in_ready); else passed++;
   endtask

   task automatic test_exception();
      exp_t e;
      int   acc;
      bit   ok, seen;
      e.res = 32'h0000_0000; e.exc = 1'b1; e.rd = 5'h02;
      issue(32'h4000_0000, 32'd4, 5'h02, e, acc, ok);
      wait_valid(40, seen);
      total++; if (!ok || !seen) $display("FAIL exc_handshake: got accept=%b valid=%b expected 1 1", ok, seen); else passed++;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++; if ({out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
            $display("FAIL exc_result: got %h/%b/%h expected %h/%b/%h", out_result, out_exception, out_rd, e.res, e.exc, e.rd);
         else passed++;
      end
      @(negedge clock);
   endtask

   task automatic test_backpressure();
      exp_t        e;
      int          acc;
      bit          ok, seen;
      logic [31:0] held;
      e.res = 32'hFFFF_FFF1; e.exc = 1'b0; e.rd = 5'h07;
      issue(32'hFFFF_FFFD, 32'd5, 5'h07, e, acc, ok);
      wait_valid(40, seen);
      total++; if (!ok || !seen) $display("FAIL bp_handshake: got accept=%b valid=%b expected 1 1", ok, seen); else passed++;
      out_ready = 1'b0;
      held = out_result;
      in_a = 32'd11; in_b = 32'd13; in_rd = 5'h1F;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if ({out_valid, in_ready, stall} !== 3'b101 || out_result !== held)
            $display("FAIL bp_hold: got valid=%b ready=%b stall=%b res=%h expected 1 0 1 %h",
                     out_valid, in_ready, stall, out_result, held);
         else passed++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      e = sb.pop_front();
      total++; if ({out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
         $display("FAIL bp_result: got %h/%b/%h expected %h/%b/%h", out_result, out_exception, out_rd, e.res, e.exc, e.rd);
      else passed++;
      @(negedge clock);
      total++; if (out_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", out_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   acc;
      bit   ok, seen;
      e.res = 32'd6; e.exc = 1'b0; e.rd = 5'h03;
      issue(32'd2, 32'd3, 5'h03, e, acc, ok);
      wait_valid(40, seen);
      e = sb.pop_front();
      total++; if (!seen || {out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
         $display("FAIL b2b_first: got valid=%b %h/%b/%h expected %h/%b/%h", seen, out_result, out_exception, out_rd, e.res, e.exc, e.rd);
      else passed++;
      e.res = 32'd20; e.exc = 1'b0; e.rd = 5'h04;
      issue(32'd4, 32'd5, 5'h04, e, acc, ok);
      total++; if (!ok || {mult_ctr_rst, out_valid, mult_a, mult_b} !== {2'b10, 32'd4, 32'd5})
         $display("FAIL b2b_start: got accept=%b ctr_rst=%b valid=%b a=%h b=%h expected 1 1 0 4 5",
                  ok, mult_ctr_rst, out_valid, mult_a, mult_b);
      else passed++;
      wait_valid(40, seen);
      e = sb.pop_front();
      total++; if (!seen || {out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
         $display("FAIL b2b_second: got valid=%b %h/%b/%h expected %h/%b/%h", seen, out_result, out_exception, out_rd, e.res, e.exc, e.rd);
      else passed++;
      @(negedge clock);
   endtask

   task automatic test_random();
      exp_t        e;
      int          acc;
      bit          ok, seen;
      logic [31:0] a, b;
      logic [RD_W-1:0] rd;
      for (int i = 0; i < 6; i++) begin
         a  = (i % 2 == 0) ? $urandom() : $urandom_range(0, 70000) - 35000;
         b  = (i % 2 == 0) ? $urandom() : $urandom_range(0, 70000) - 35000;
         rd = RD_W'($urandom_range(0, 31));
         issue(a, b, rd, mul_model(a, b, rd), acc, ok);
         wait_valid(40, seen);
         if (!ok || !seen || sb.size() == 0) begin
            total++;
            $display("FAIL rand_handshake: got accept=%b valid=%b expected 1 1", ok, seen);
            sb.delete();
         end else begin
            e = sb.pop_front();
            total++; if ({out_result, out_exception, out_rd} !== {e.res, e.exc, e.rd})
               $display("FAIL rand_result: got %h/%b/%h expected %h/%b/%h (a=%h b=%h)",
                        out_result, out_exception, out_rd, e.res, e.exc, e.rd, a, b);
            else passed++;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid_busy();
      exp_t e;
      int   acc;
      bit   ok, seen;
      e = mul_model(32'd9, 32'd9, 5'h09);
      issue(32'd9, 32'd9, 5'h09, e, acc, ok);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      total++; if (mult_ctr_rst !== 1'b1) $display("FAIL abort_ctr_rst: got %b expected 1", mult_ctr_rst); else passed++;
      @(negedge clock);
      reset = 1'b0;
      sb.delete();
      #1;
      total++; if ({in_ready, out_valid, mult_ctr_rst} !== 3'b100)
         $display("FAIL abort_idle: got ready=%b valid=%b ctr_rst=%b expected 1 0 0", in_ready, out_valid, mult_ctr_rst);
      else passed++;
      wait_valid(25, seen);
      total++; if (seen) $display("FAIL abort_no_result: got out_valid=1 expected 0"); else passed++;
   endtask

`ifdef MULT_ISSUE_TIMEOUT_EN
   task automatic test_timeout();
      exp_t e;
      int   acc;
      bit   ok, seen;
      m_hold = 1'b1;
      e.res = 32'h0; e.exc = 1'b1; e.rd = 5'h15;
      issue(32'd3, 32'd3, 5'h15, e, acc, ok);
      wait_valid(60, seen);
      total++; if (!seen || (cyc - acc) != TMO + 1)
         $display("FAIL tmo_latency: got seen=%b cycles=%0d expected %0d", seen, cyc - acc, TMO + 1);
      else passed++;
      e = sb.pop_front();
      total++; if ({out_result, out_exception, out_rd, out_timeout} !== {e.res, e.exc, e.rd, 1'b1})
         $display("FAIL tmo_result: got %h/%b/%h/%b expected %h/%b/%h/1",
                  out_result, out_exception, out_rd, out_timeout, e.res, e.exc, e.rd);
      else passed++;
      m_hold = 1'b0;
      @(negedge clock);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_exception();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_busy();
`ifdef MULT_ISSUE_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
